// File: rtl/adder_tree_pipelined.sv
// Pipelined pairwise adder tree with per-lane frame accumulator.
// Valid and framing flags travel with the data through every register stage.
module adder_tree_pipelined #(
    parameter int BITS          = 16,
    parameter int OVERHEAD_BITS = 12,
    parameter int NB_INPUTS     = 8,
    parameter int LANES         = 15,
    parameter int LEVELS        = 1,
    parameter int SATURATE      = 0,
    localparam int W            = 2*BITS + OVERHEAD_BITS,
    localparam int G            = NB_INPUTS >> LEVELS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         in_acc,
    input  logic [NB_INPUTS*LANES*W-1:0] in_data,
    output logic                         out_valid,
    output logic [G*LANES*W-1:0]         out_data
);

    localparam int TW = G*LANES*W;

    // Valid-only stream: no ready, a beat is taken on every edge with in_valid=1
    // and appears on out_valid exactly LEVELS+1 edges later (or not at all for
    // non-final accumulate beats).
    function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (SATURATE != 0 && s[W] != s[W-1])
            add_w = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            add_w = s[W-1:0];
    endfunction

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int GN = NB_INPUTS >> l;
        logic [GN*LANES*W-1:0] data;
        logic                  valid;
        logic                  first;
        logic                  last;
        logic                  acc;

        if (l == 0) begin : g_src
            assign data  = in_data;
            assign valid = in_valid;
            assign first = in_first;
            assign last  = in_last;
            assign acc   = in_acc;
        end else begin : g_add
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data  <= '0;
                    valid <= 1'b0;
                    first <= 1'b0;
                    last  <= 1'b0;
                    acc   <= 1'b0;
                end else begin
                    // Group k of this level = groups 2k and 2k+1 of the level above.
                    for (int k = 0; k < GN; k++) begin
                        for (int a = 0; a < LANES; a++) begin
                            data[W*(a+k*LANES) +: W] <=
                                add_w(g_lvl[l-1].data[W*(a+2*k*LANES) +: W],
                                      g_lvl[l-1].data[W*(a+(2*k+1)*LANES) +: W]);
                        end
                    end
                    valid <= g_lvl[l-1].valid;
                    first <= g_lvl[l-1].first;
                    last  <= g_lvl[l-1].last;
                    acc   <= g_lvl[l-1].acc;
                end
            end
        end
    end

    logic [TW-1:0] tree_data;
    logic          tree_valid;
    logic          tree_first;
    logic          tree_last;
    logic          tree_acc;

    assign tree_data  = g_lvl[LEVELS].data;
    assign tree_valid = g_lvl[LEVELS].valid;
    assign tree_first = g_lvl[LEVELS].first;
    assign tree_last  = g_lvl[LEVELS].last;
    assign tree_acc   = g_lvl[LEVELS].acc;

    logic [TW-1:0] acc_reg;
    logic [TW-1:0] acc_next;

    // A first beat restarts the frame; otherwise fold onto the running total.
    always_comb begin
        acc_next = tree_data;
        if (!tree_first) begin
            for (int i = 0; i < G*LANES; i++) begin
                acc_next[W*i +: W] = add_w(acc_reg[W*i +: W], tree_data[W*i +: W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (tree_valid) begin
                if (!tree_acc) begin
                    out_valid <= 1'b1;
                    out_data  <= tree_data;
                end else begin
                    acc_reg   <= acc_next;
                    out_valid <= tree_last;
                    if (tree_last)
                        out_data <= acc_next;
                end
            end
        end
    end

endmodule
